// File: rtl/pztb_pkg.sv
// Shared types for the 1r1w access controller. Define MEM_1R1W_ACCESS_CTRL_FORWARD_EN
// to forward same-cycle write data into a colliding read instead of stalling the read.
package pztb_pkg;

    typedef enum logic {
        COLL_STALL   = 1'b0,
        COLL_FORWARD = 1'b1
    } coll_mode_e;

`ifdef MEM_1R1W_ACCESS_CTRL_FORWARD_EN
    localparam coll_mode_e COLL_MODE = COLL_FORWARD;
`else
    localparam coll_mode_e COLL_MODE = COLL_STALL;
`endif

    // Tracks the read whose memory data arrives this cycle and whether it needs a merge.
    typedef struct packed {
        logic valid;
        logic fwd;
    } rsp_entry_t;

endpackage

// File: rtl/mem_1r1w_rsp_fifo.sv
// Two-entry response FIFO with valid/ready on both sides and 1-bit wrapping pointers.
module mem_1r1w_rsp_fifo #(
    parameter int DATAW = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [DATAW-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [DATAW-1:0] pop_data
);

    logic [DATAW-1:0] slot_q [2];
    logic [DATAW-1:0] slot_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       used_q, used_d;
    logic             push_fire, pop_fire;

    always_comb begin
        push_ready = (used_q != 2'd2);
        pop_valid  = (used_q != 2'd0);
        pop_data   = slot_q[rd_ptr_q];
        push_fire  = push_valid && push_ready;
        pop_fire   = pop_valid && pop_ready;

        slot_d   = slot_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        used_d   = used_q;

        if (push_fire) begin
            slot_d[wr_ptr_q] = push_data;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop_fire) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push_fire, pop_fire})
            2'b10:   used_d = used_q + 2'd1;
            2'b01:   used_d = used_q - 2'd1;
            default: used_d = used_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            used_q    <= 2'd0;
        end else begin
            slot_q    <= slot_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            used_q    <= used_d;
        end
    end

endmodule

// File: rtl/mem_1r1w_access_ctrl.sv
// Access controller for a 1-read/1-write SRAM with 1-cycle read latency and ordered responses.
// Collision handling selected by MEM_1R1W_ACCESS_CTRL_FORWARD_EN (see pztb_pkg).
module mem_1r1w_access_ctrl #(
    parameter int DATAW = 32,
    parameter int WORDW = 1024,
    parameter int ADDRW = $clog2(WORDW)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [ADDRW-1:0] wr_addr,
    input  logic [DATAW-1:0] wr_data,
    input  logic [DATAW-1:0] wr_strb,
    input  logic             rd_valid,
    output logic             rd_ready,
    input  logic [ADDRW-1:0] rd_addr,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DATAW-1:0] rsp_data,
    output logic [ADDRW-1:0] mem_adra,
    output logic [DATAW-1:0] mem_da,
    output logic [DATAW-1:0] mem_wema,
    output logic             mem_wea,
    output logic             mem_mea,
    output logic [ADDRW-1:0] mem_adrb,
    output logic             mem_meb,
    input  logic [DATAW-1:0] mem_qb
);

    import pztb_pkg::*;

    logic             wr_fire, rd_fire, rsp_fire, addr_match, coll_stall;
    logic [1:0]       count_q, count_d;
    rsp_entry_t       trk_q, trk_d;
    logic [DATAW-1:0] fwd_data_q, fwd_data_d;
    logic [DATAW-1:0] fwd_strb_q, fwd_strb_d;
    logic [DATAW-1:0] cap_data;
    logic             fifo_push_ready, fifo_pop_valid;
    logic [DATAW-1:0] fifo_pop_data;

    always_comb begin
        addr_match = (rd_addr == wr_addr);
        coll_stall = (COLL_MODE == COLL_STALL) && wr_valid && addr_match;

        wr_ready  = !rst;
        wr_fire   = wr_valid && wr_ready;
        // count covers in-flight plus queued reads, so a free count slot implies FIFO space.
        rd_ready  = !rst && (count_q < 2'd2) && !coll_stall && fifo_push_ready;
        rd_fire   = rd_valid && rd_ready;
        rsp_valid = !rst && fifo_pop_valid;
        rsp_data  = rst ? '0 : fifo_pop_data;
        rsp_fire  = rsp_valid && rsp_ready;

        mem_mea  = wr_fire;
        mem_wea  = wr_fire;
        mem_adra = rst ? '0 : wr_addr;
        mem_da   = rst ? '0 : wr_data;
        mem_wema = rst ? '0 : wr_strb;
        mem_meb  = rd_fire;
        mem_adrb = rst ? '0 : rd_addr;

        count_d = count_q;
        case ({rd_fire, rsp_fire})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        // The memory reads old data on a collision; keep the write to merge at capture.
        trk_d.valid = rd_fire;
        trk_d.fwd   = (COLL_MODE == COLL_FORWARD) && rd_fire && wr_fire && addr_match;
        fwd_data_d  = trk_d.fwd ? wr_data : fwd_data_q;
        fwd_strb_d  = trk_d.fwd ? wr_strb : fwd_strb_q;

        cap_data = trk_q.fwd ? ((mem_qb & ~fwd_strb_q) | (fwd_data_q & fwd_strb_q)) : mem_qb;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= 2'd0;
            trk_q      <= '0;
            fwd_data_q <= '0;
            fwd_strb_q <= '0;
        end else begin
            count_q    <= count_d;
            trk_q      <= trk_d;
            fwd_data_q <= fwd_data_d;
            fwd_strb_q <= fwd_strb_d;
        end
    end

    mem_1r1w_rsp_fifo #(
        .DATAW (DATAW)
    ) u_rsp_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (trk_q.valid),
        .push_ready (fifo_push_ready),
        .push_data  (cap_data),
        .pop_valid  (fifo_pop_valid),
        .pop_ready  (rsp_ready),
        .pop_data   (fifo_pop_data)
    );

endmodule

// File: tb/tb_mem_1r1w_access_ctrl.sv
// Bench for mem_1r1w_access_ctrl: behavioural SRAM plus a response-queue reference model.
`timescale 1ns/1ps
module tb_mem_1r1w_access_ctrl;

    localparam int DATAW = 32;
    localparam int WORDW = 1024;
    localparam int ADDRW = 10;
`ifdef MEM_1R1W_ACCESS_CTRL_FORWARD_EN
    localparam bit STALL = 1'b0;
`else
    localparam bit STALL = 1'b1;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr_valid = 1'b0, wr_ready;
    logic [ADDRW-1:0] wr_addr = '0;
    logic [DATAW-1:0] wr_data = '0, wr_strb = '0;
    logic             rd_valid = 1'b0, rd_ready;
    logic [ADDRW-1:0] rd_addr = '0;
    logic             rsp_valid, rsp_ready = 1'b0;
    logic [DATAW-1:0] rsp_data;
    logic [ADDRW-1:0] mem_adra, mem_adrb;
    logic [DATAW-1:0] mem_da, mem_wema;
    logic             mem_wea, mem_mea, mem_meb;
    logic [DATAW-1:0] mem_qb = '0;

    mem_1r1w_access_ctrl #(.DATAW(DATAW), .WORDW(WORDW), .ADDRW(ADDRW)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_strb(wr_strb),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .mem_adra(mem_adra), .mem_da(mem_da), .mem_wema(mem_wema),
        .mem_wea(mem_wea), .mem_mea(mem_mea),
        .mem_adrb(mem_adrb), .mem_meb(mem_meb), .mem_qb(mem_qb)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural SRAM, read-before-write ----------------
    logic [DATAW-1:0] mem_arr [WORDW];
    always @(posedge clk) begin
        if (mem_meb) mem_qb <= mem_arr[mem_adrb];
        if (mem_mea && mem_wea)
            mem_arr[mem_adra] <= (mem_arr[mem_adra] & ~mem_wema) | (mem_da & mem_wema);
    end

    // ---------------- reference model and scoreboard ----------------
    logic [DATAW-1:0] ref_mem [WORDW];
    logic [DATAW-1:0] exp_q [$];
    int               avail_q [$];
    int               total = 0;
    int               bad = 0;
    logic             acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check combinational outputs, then advance the model.
    task automatic step(input logic wv, input logic [ADDRW-1:0] wa, input logic [DATAW-1:0] wd,
                        input logic [DATAW-1:0] ws, input logic rv, input logic [ADDRW-1:0] ra,
                        input logic rr, output logic accepted);
        logic             er, ev;
        logic [DATAW-1:0] rdat;
        @(negedge clk);
        wr_valid = wv; wr_addr = wa; wr_data = wd; wr_strb = ws;
        rd_valid = rv; rd_addr = ra; rsp_ready = rr;
        #1;
        er = (exp_q.size() < 2) && !(STALL && wv && (wa == ra));
        ev = (exp_q.size() > 0) && (avail_q[0] <= cyc);
        chk("wr_ready", 64'(wr_ready), 64'(1'b1));
        chk("rd_ready", 64'(rd_ready), 64'(er));
        chk("rsp_valid", 64'(rsp_valid), 64'(ev));
        if (ev) chk("rsp_data", 64'(rsp_data), 64'(exp_q[0]));
        chk("mem_meb", 64'(mem_meb), 64'(rv && er));
        if (rv && er) chk("mem_adrb", 64'(mem_adrb), 64'(ra));
        chk("mem_mea", 64'(mem_mea), 64'(wv));
        chk("mem_wea", 64'(mem_wea), 64'(wv));
        if (wv) begin
            chk("mem_adra", 64'(mem_adra), 64'(wa));
            chk("mem_da", 64'(mem_da), 64'(wd));
            chk("mem_wema", 64'(mem_wema), 64'(ws));
        end
        if (ev && rr) begin
            void'(exp_q.pop_front());
            void'(avail_q.pop_front());
        end
        accepted = rv && er;
        if (accepted) begin
            rdat = ref_mem[ra];
            if (wv && (wa == ra)) rdat = (rdat & ~ws) | (wd & ws);
            exp_q.push_back(rdat);
            avail_q.push_back(cyc + 2);
        end
        if (wv) ref_mem[wa] = (ref_mem[wa] & ~ws) | (wd & ws);
    endtask

    task automatic idle(input logic rr);
        logic a;
        step(1'b0, '0, '0, '0, 1'b0, '0, rr, a);
    endtask

    // Asserts reset mid-cycle with live requests and checks every output is forced low at once.
    task automatic do_reset();
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = 10'h5; wr_data = '1; wr_strb = '1;
        rd_valid = 1'b1; rd_addr = 10'h3; rsp_ready = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("rst_wr_ready", 64'(wr_ready), 64'(0));
        chk("rst_rd_ready", 64'(rd_ready), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_data", 64'(rsp_data), 64'(0));
        chk("rst_mem_mea", 64'(mem_mea), 64'(0));
        chk("rst_mem_wea", 64'(mem_wea), 64'(0));
        chk("rst_mem_meb", 64'(mem_meb), 64'(0));
        chk("rst_mem_adra", 64'(mem_adra), 64'(0));
        chk("rst_mem_da", 64'(mem_da), 64'(0));
        chk("rst_mem_wema", 64'(mem_wema), 64'(0));
        chk("rst_mem_adrb", 64'(mem_adrb), 64'(0));
        exp_q.delete();
        avail_q.delete();
        @(negedge clk);
        wr_valid = 1'b0; rd_valid = 1'b0; wr_addr = '0; rd_addr = '0;
        wr_data = '0; wr_strb = '0;
        rst = 1'b0;
    endtask

    // ---------------- directed then random stimulus ----------------
    initial begin
        for (int i = 0; i < WORDW; i++) begin
            mem_arr[i] = '0;
            ref_mem[i] = '0;
        end

        do_reset();

        // single write then read, data visible two cycles after the read fires
        step(1'b1, 10'h10, 32'hDEADBEEF, '1, 1'b0, '0, 1'b1, acc);
        step(1'b0, '0, '0, '0, 1'b1, 10'h10, 1'b1, acc);
        repeat (3) idle(1'b1);

        // back-to-back reads with the response side always ready
        for (int i = 0; i < 8; i++) step(1'b0, '0, '0, '0, 1'b1, ADDRW'(i), 1'b1, acc);
        repeat (3) idle(1'b1);

        // backpressure: only two reads may be outstanding
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, '0, 1'b1, 10'h10, 1'b0, acc);
        repeat (4) idle(1'b1);

        // same-cycle collision with a partial write
        step(1'b1, 10'h20, 32'h11111111, '1, 1'b0, '0, 1'b1, acc);
        idle(1'b1);
        step(1'b1, 10'h20, 32'hAAAAAAAA, 32'h0000FFFF, 1'b1, 10'h20, 1'b1, acc);
        if (!acc) step(1'b0, '0, '0, '0, 1'b1, 10'h20, 1'b1, acc);
        repeat (3) idle(1'b1);

        // reset with two reads outstanding, then a clean read
        step(1'b0, '0, '0, '0, 1'b1, 10'h10, 1'b0, acc);
        step(1'b0, '0, '0, '0, 1'b1, 10'h20, 1'b0, acc);
        do_reset();
        idle(1'b1);
        step(1'b0, '0, '0, '0, 1'b1, 10'h20, 1'b1, acc);
        repeat (3) idle(1'b1);

        // random traffic over a small address window to provoke collisions
        for (int i = 0; i < 400; i++) begin
            logic [DATAW-1:0] ws;
            ws = ($urandom_range(0, 3) == 0) ? '1 : DATAW'($urandom);
            step(1'($urandom_range(0, 1)), ADDRW'($urandom_range(0, 7)), DATAW'($urandom), ws,
                 1'($urandom_range(0, 1)), ADDRW'($urandom_range(0, 7)),
                 1'($urandom_range(0, 3) != 0), acc);
        end
        repeat (5) idle(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
